// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register pending (busy) scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_sb #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned ADW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADW-1:0]   a1,
  input  logic [ADW-1:0]   a2,
  output logic [DATAW-1:0] rd1,
  output logic [DATAW-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic [ADW-1:0]   a3,
  input  logic [DATAW-1:0] wr,
  input  logic             wrenable,
  input  logic             iss_en,
  input  logic [ADW-1:0]   iss_dst,
  output logic [ADW:0]     pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADW;

  logic [DATAW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADW:0]     cnt_next;
  logic             wr_hit;
  logic             fwd1;
  logic             fwd2;

  assign wr_hit = wrenable && (a3 != '0);

  // Clear before set so a same-edge issue and writeback leave the bit pending.
  always_comb begin
    busy_next = busy;
    if (wrenable) busy_next[a3] = 1'b0;
    if (iss_en && (iss_dst != '0)) busy_next[iss_dst] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Register 0 can never be pending, so the count tops out at DEPTH-1.
  always_comb begin
    cnt_next = (ADW+1)'($countones(busy_next));
  end

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    fwd1 = wr_hit && (a1 == a3);
    fwd2 = wr_hit && (a2 == a3);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '{default: '0};
      busy     <= '0;
      pend_cnt <= '0;
      rd1      <= '0;
      rd2      <= '0;
      busy1    <= 1'b0;
      busy2    <= 1'b0;
    end else begin
      if (wr_hit) mem[a3] <= wr;
      busy     <= busy_next;
      pend_cnt <= cnt_next;
      rd1      <= fwd1 ? wr : mem[a1];
      rd2      <= fwd2 ? wr : mem[a2];
      busy1    <= fwd1 ? busy_next[a1] : busy[a1];
      busy2    <= fwd2 ? busy_next[a2] : busy[a2];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

  localparam int DATAW = 32;
  localparam int ADW   = 5;
  localparam int DEPTH = 1 << ADW;

  logic             clk;
  logic             rst_n;
  logic [ADW-1:0]   a1, a2, a3, iss_dst;
  logic [DATAW-1:0] rd1, rd2, wr;
  logic             busy1, busy2, wrenable, iss_en;
  logic [ADW:0]     pend_cnt;

  regfile_sb #(.DATAW(DATAW), .ADW(ADW)) dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .a3(a3), .wr(wr), .wrenable(wrenable),
    .iss_en(iss_en), .iss_dst(iss_dst), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DATAW-1:0] m_mem [DEPTH];
  bit               m_busy [DEPTH];
  logic [DATAW-1:0] exp_rd1, exp_rd2;
  bit               exp_b1, exp_b2;
  int               exp_cnt;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 0;
    end
  endtask

  // Predict the post-edge outputs from the current inputs, update the model, advance one edge.
  task automatic tick();
    bit post [DEPTH];
    int n;
    for (int i = 0; i < DEPTH; i++) post[i] = m_busy[i];
    if (wrenable) post[a3] = 0;
    if (iss_en && iss_dst != 0) post[iss_dst] = 1;
    exp_rd1 = m_mem[a1];
    exp_rd2 = m_mem[a2];
    exp_b1  = m_busy[a1];
    exp_b2  = m_busy[a2];
`ifdef REGFILE_BYPASS_EN
    if (wrenable && a3 != 0 && a1 == a3) begin exp_rd1 = wr; exp_b1 = post[a1]; end
    if (wrenable && a3 != 0 && a2 == a3) begin exp_rd2 = wr; exp_b2 = post[a2]; end
`endif
    if (wrenable && a3 != 0) m_mem[a3] = wr;
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = post[i];
      if (post[i]) n++;
    end
    exp_cnt = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wrenable = 0; iss_en = 0; a3 = '0; wr = '0; iss_dst = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; a1 = '0; a2 = '0; idle_inputs();
    model_reset();
    #3;
    checks++;
    if (rd1 !== '0 || rd2 !== '0 || busy1 !== 0 || busy2 !== 0 || pend_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state rd1=%h rd2=%h b1=%b b2=%b cnt=%0d, want all 0", rd1, rd2, busy1, busy2, pend_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    a1 = 5; a2 = 31;
    tick();
    checks++;
    if (rd1 !== 0 || rd2 !== 0 || busy1 !== 0 || busy2 !== 0 || pend_cnt !== 0) begin
      failures++;
      $display("FAIL post_reset_read rd1=%h rd2=%h b1=%b b2=%b cnt=%0d, want all 0", rd1, rd2, busy1, busy2, pend_cnt);
    end
  endtask

  task automatic test_write_read();
    a1 = 0; a2 = 0;
    wrenable = 1; a3 = 7; wr = 32'hDEADBEEF; tick();
    idle_inputs(); a1 = 7; tick();
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write_read rd1=%h want deadbeef", rd1);
    end
    wrenable = 1; a3 = 0; wr = 32'h1234; a2 = 0; tick();
    idle_inputs(); tick();
    checks++;
    if (rd2 !== 32'h0) begin
      failures++; $display("FAIL reg0_write rd2=%h want 0", rd2);
    end
  endtask

  task automatic test_scoreboard();
    a1 = 0; a2 = 0;
    iss_en = 1; iss_dst = 9;  tick();
    iss_dst = 12; tick();
    iss_en = 0; tick();
    checks++;
    if (pend_cnt !== 2) begin failures++; $display("FAIL issue_count cnt=%0d want 2", pend_cnt); end
    a1 = 9; tick();
    checks++;
    if (busy1 !== 1) begin failures++; $display("FAIL busy_set busy1=%b want 1", busy1); end
    a1 = 0; wrenable = 1; a3 = 9; wr = 32'hCAFE0009; tick();
    idle_inputs(); a1 = 9; tick();
    checks++;
    if (pend_cnt !== 1 || busy1 !== 0 || rd1 !== 32'hCAFE0009) begin
      failures++; $display("FAIL writeback_clear cnt=%0d busy1=%b rd1=%h want 1 0 cafe0009", pend_cnt, busy1, rd1);
    end
    iss_en = 1; iss_dst = 12; tick();
    iss_dst = 0; tick();
    idle_inputs(); a2 = 0; tick();
    checks++;
    if (pend_cnt !== 1 || busy2 !== 0) begin
      failures++; $display("FAIL reissue_and_reg0 cnt=%0d busy2=%b want 1 0", pend_cnt, busy2);
    end
    wrenable = 1; a3 = 20; wr = 32'h20; tick();
    idle_inputs(); tick();
    checks++;
    if (pend_cnt !== 1) begin failures++; $display("FAIL write_nonbusy cnt=%0d want 1", pend_cnt); end
  endtask

  task automatic test_same_edge();
    a1 = 0; a2 = 0;
    iss_en = 1; iss_dst = 4; wrenable = 1; a3 = 4; wr = 32'h55; tick();
    idle_inputs();
    checks++;
    if (pend_cnt !== 2) begin failures++; $display("FAIL same_edge_count cnt=%0d want 2", pend_cnt); end
    a1 = 4; tick();
    checks++;
    if (rd1 !== 32'h55 || busy1 !== 1) begin
      failures++; $display("FAIL same_edge_state rd1=%h busy1=%b want 55 1", rd1, busy1);
    end
  endtask

  task automatic test_bypass();
    logic [DATAW-1:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h11;
`endif
    a1 = 0; wrenable = 1; a3 = 3; wr = 32'h11; tick();
    a1 = 3; wr = 32'hA5A5A5A5; tick();
    idle_inputs();
    checks++;
    if (rd1 !== want || busy1 !== 0) begin
      failures++; $display("FAIL same_edge_read rd1=%h busy1=%b want %h 0", rd1, busy1, want);
    end
    tick();
    checks++;
    if (rd1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL after_write rd1=%h want a5a5a5a5", rd1); end
  endtask

  task automatic test_reset_mid();
    a1 = 7; a2 = 0;
    iss_en = 1;
    for (int r = 1; r <= 3; r++) begin iss_dst = r[ADW-1:0]; tick(); end
    idle_inputs(); tick();
    checks++;
    if (pend_cnt !== 5 || rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL pre_reset cnt=%0d rd1=%h want 5 deadbeef", pend_cnt, rd1);
    end
    #2;
    rst_n = 0;
    wrenable = 1; a3 = 5; wr = 32'hFF; iss_en = 1; iss_dst = 6;
    #1;
    checks++;
    if (rd1 !== 0 || pend_cnt !== 0 || busy1 !== 0) begin
      failures++; $display("FAIL async_reset rd1=%h cnt=%0d busy1=%b want 0", rd1, pend_cnt, busy1);
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    idle_inputs();
    @(posedge clk); #1;
    a1 = 5; a2 = 6; tick();
    checks++;
    if (rd1 !== 0 || busy2 !== 0 || pend_cnt !== 0) begin
      failures++; $display("FAIL after_reset rd1=%h busy2=%b cnt=%0d want 0 0 0", rd1, busy2, pend_cnt);
    end
    a1 = 7; tick();
    checks++;
    if (rd1 !== 0) begin failures++; $display("FAIL reset_clears_mem rd1=%h want 0", rd1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a1       = ADW'($urandom);
      a2       = ($urandom_range(0, 3) == 0) ? a1 : ADW'($urandom);
      a3       = ($urandom_range(0, 2) == 0) ? a1 : ADW'($urandom);
      wr       = $urandom;
      wrenable = ($urandom_range(0, 1) == 1);
      iss_en   = ($urandom_range(0, 9) < 4);
      iss_dst  = ($urandom_range(0, 4) == 0) ? a3 : ADW'($urandom);
      tick();
      checks++;
      if (rd1 !== exp_rd1 || rd2 !== exp_rd2 || busy1 !== exp_b1 || busy2 !== exp_b2 || pend_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL random[%0d] rd1=%h/%h rd2=%h/%h b1=%b/%b b2=%b/%b cnt=%0d/%0d (got/want)",
                 n, rd1, exp_rd1, rd2, exp_rd2, busy1, exp_b1, busy2, exp_b2, pend_cnt, exp_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_same_edge();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
